// File: rtl/fp_pkg.sv
// Shared definitions for the FP32 accumulate sequencer: state encoding,
// FP32 field widths and a sign-agnostic zero test.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int FP32_W = 1 + EXP_W + MAN_W;

    localparam logic [FP32_W-1:0] FP32_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        ACC,
        DONE
    } fsm_state_e;

    // Magnitude bits only: +0 and -0 both count as zero; denormals are not expected.
    function automatic logic is_zero(input logic [EXP_W+MAN_W-1:0] mag);
        return (mag == '0);
    endfunction

endpackage

// File: rtl/fp_accum_ctrl.sv
// Streams FP32 operands through an external shared adder and returns their sum.
// Zero operands bypass the adder, which has no zero handling of its own.
module fp_accum_ctrl
    import fp_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              flush,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP32_W-1:0] in_data,
    output logic [FP32_W-1:0] add_a,
    output logic [FP32_W-1:0] add_b,
    input  logic [FP32_W-1:0] add_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FP32_W-1:0] out_data
);

    // Handshakes: a beat transfers on the rising edge where valid && ready are
    // both high; the sender holds valid and data stable until that edge.

    fsm_state_e        state_q, state_d;
    logic [FP32_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0]  rem_q, rem_d;

    assign busy      = (state_q != IDLE);
    assign in_ready  = (state_q == FIRST) || (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign out_data  = acc_q;
    assign add_a     = acc_q;
    assign add_b     = in_data;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        rem_d   = len;
                        state_d = FIRST;
                    end else begin
                        acc_d   = FP32_ZERO;
                        state_d = DONE;
                    end
                end
            end
            FIRST: begin
                if (in_valid) begin
                    acc_d   = in_data;
                    rem_d   = rem_q - LEN_W'(1);
                    state_d = (rem_q == LEN_W'(1)) ? DONE : ACC;
                end
            end
            ACC: begin
                if (in_valid) begin
                    if (is_zero(in_data[EXP_W+MAN_W-1:0])) begin
                        acc_d = acc_q;
                    end else if (is_zero(acc_q[EXP_W+MAN_W-1:0])) begin
                        acc_d = in_data;
                    end else begin
                        acc_d = add_sum;
                    end
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over everything; the partial sum stays visible in acc.
        if (flush) begin
            state_d = IDLE;
            rem_d   = '0;
            acc_d   = acc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= FP32_ZERO;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_fp_accum_ctrl.sv
// Self-checking bench for fp_accum_ctrl: directed scenarios plus randomized jobs
// scored against a real-arithmetic sum of the operands.
module tb_fp_accum_ctrl;

    localparam int LEN_W = 8;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [LEN_W-1:0]  len_i;
    logic              flush;
    logic              busy;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic [31:0]       add_a;
    logic [31:0]       add_b;
    logic [31:0]       add_sum;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    fp_accum_ctrl #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len_i), .flush(flush),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FP32 <-> real, exact for the short dyadic values used here
    function automatic real to_real(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:0] == 31'd0) return 0.0;
        d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] to_bits(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    // Stand-in for the tile's shared adder
    assign add_sum = to_bits(to_real(add_a) + to_real(add_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int l);
        start = 1'b1;
        len_i = LEN_W'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [31:0] v, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = v;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) check("feed_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic collect(input int stall);
        int n;
        logic [31:0] held;
        logic [31:0] exp;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        if (n == 100) check("out_timeout", 32'(out_valid), 32'd1);
        held = out_data;
        repeat (stall) begin
            tick();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", out_data, held);
        end
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        // Sign of a zero sum is not normalised; compare magnitude-zero as +0
        check("rand_sum", (out_data[30:0] == 31'd0) ? 32'h0 : out_data, exp);
        drain();
        check("rand_idle", 32'(busy), 32'd0);
    endtask

    function automatic logic [31:0] rand_operand();
        int k;
        k = int'($urandom_range(0, 64)) - 32;
        if (k == 0) return ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h0;
        return to_bits(real'(k) / 4.0);
    endfunction

    initial begin
        logic [31:0] ops[$];
        real sum;
        int l;

        rst_n = 1'b0; start = 1'b0; len_i = '0; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset and idle
        #13;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd0);

        // Three-operand sum, back-to-back handshakes
        start_job(3);
        check("j3_busy", 32'(busy), 32'd1);
        check("j3_in_ready", 32'(in_ready), 32'd1);
        feed(32'h3F80_0000, 0);
        check("j3_ready1", 32'(in_ready), 32'd1);
        feed(32'h4000_0000, 0);
        check("j3_ready2", 32'(in_ready), 32'd1);
        feed(32'h3F00_0000, 0);
        check("j3_valid", 32'(out_valid), 32'd1);
        check("j3_data", out_data, 32'h4060_0000);
        drain();
        check("j3_idle", 32'(busy), 32'd0);

        // Zero bypass and back-pressure
        start_job(4);
        feed(32'h0000_0000, 0);
        check("z_acc0", add_a, 32'h0);
        feed(32'h4040_0000, 0);
        check("z_acc1", add_a, 32'h4040_0000);
        tick();
        check("z_gap_hold", add_a, 32'h4040_0000);
        check("z_gap_novalid", 32'(out_valid), 32'd0);
        feed(32'h8000_0000, 0);
        check("z_negzero_hold", add_a, 32'h4040_0000);
        feed(32'h3F80_0000, 0);
        check("z_valid", 32'(out_valid), 32'd1);
        check("z_data", out_data, 32'h4080_0000);
        drain();

        // len=0 and output stall with ignored start
        start_job(0);
        check("l0_valid", 32'(out_valid), 32'd1);
        check("l0_data", out_data, 32'h0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                start = 1'b1;
                len_i = LEN_W'(3);
            end
            tick();
            start = 1'b0;
            check("l0_stall_valid", 32'(out_valid), 32'd1);
            check("l0_stall_data", out_data, 32'h0);
        end
        drain();
        check("l0_released", 32'(out_valid), 32'd0);
        tick();
        check("l0_no_queue", 32'(busy), 32'd0);

        // Flush mid-job
        start_job(5);
        feed(32'h3F80_0000, 0);
        feed(32'h4000_0000, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_busy", 32'(busy), 32'd0);
        check("fl_in_ready", 32'(in_ready), 32'd0);
        check("fl_acc_kept", add_a, 32'h4040_0000);
        repeat (3) tick();
        check("fl_no_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-job, then a fresh one-operand job
        start_job(5);
        feed(32'h4000_0000, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_in_ready", 32'(in_ready), 32'd0);
        check("ar_acc", add_a, 32'h0);
        check("ar_out_data", out_data, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        start_job(1);
        feed(32'h4000_0000, 0);
        check("ar_job_valid", 32'(out_valid), 32'd1);
        check("ar_job_data", out_data, 32'h4000_0000);
        drain();

        // Randomized jobs with input gaps and output stalls
        for (int j = 0; j < 30; j++) begin
            l = int'($urandom_range(0, 12));
            ops.delete();
            sum = 0.0;
            for (int i = 0; i < l; i++) begin
                ops.push_back(rand_operand());
                sum += to_real(ops[i]);
            end
            exp_q.push_back(to_bits(sum));
            start_job(l);
            foreach (ops[i]) begin
                check("rand_b_port", add_b, in_data);
                feed(ops[i], int'($urandom_range(0, 2)));
            end
            collect(int'($urandom_range(0, 3)));
        end
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_accum_ctrl.md
Name: fp_accum_ctrl

Overview:
Sequencer that reduces a stream of FP32 operands to one FP32 sum using a single shared combinational FP32 adder instantiated beside it in the MAC tile. It accepts a job (start + length), streams operands in over valid/ready, drives the adder operands, and registers the adder result each cycle. It returns the final sum over valid/ready. The adder has no zero/denormal handling, so this block bypasses the adder for zero operands.

Parameters:
LEN_W, 8, width of job length and remaining-element counter (max job = 2^LEN_W-1 elements)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset; one clock, asynchronous assert, active-low
start  in  1  job request pulse; sampled only in IDLE
len  in  LEN_W  number of operands in job; sampled with start
flush  in  1  synchronous abort; returns to IDLE next cycle
busy  out  1  high in any state other than IDLE
in_valid  in  1  operand valid
in_ready  out  1  operand accepted when in_valid && in_ready
in_data  in  32  FP32 operand
add_a  out  32  adder operand A (= acc)
add_b  out  32  adder operand B (= in_data)
add_sum  in  32  combinational adder result
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready
out_data  out  32  final FP32 sum (= acc)

Behaviour:
- Reset (rst_n low, async): state=IDLE, acc=32'h0, remaining=0; busy=0, in_ready=0, out_valid=0, out_data=0.
- Registers: acc[31:0], remaining[LEN_W-1:0], state. add_a/add_b are combinational from acc/in_data; these ports are always driven.
- States: IDLE, FIRST, ACC, DONE.
- IDLE: in_ready=0, out_valid=0. On start && len!=0: remaining<=len, go to FIRST. On start && len==0: acc<=0, go to DONE. start outside IDLE is ignored with no queuing.
- FIRST: in_ready=1. On handshake: acc<=in_data, remaining<=remaining-1. If remaining==1, go to DONE; otherwise go to ACC. The adder is not used.
- ACC: in_ready=1; one operand per cycle, result visible in acc the next cycle. On handshake:
  - in_data[30:0]==0 (±0): acc unchanged.
  - else if acc[30:0]==0: acc<=in_data.
  - else: acc<=add_sum.
  - In all three cases remaining<=remaining-1. If remaining==1, go to DONE.
- No handshake (in_valid=0): hold all state.
- DONE: in_ready=0, out_valid=1, out_data=acc, held stable until out_ready. On out_ready go to IDLE. A start in the same cycle is ignored. The next job can start the cycle after.
- Latency: len operands take at least len cycles after start. out_valid rises the cycle after the last operand handshake.
- flush: highest priority over start and handshakes. state<=IDLE and remaining<=0; acc is left unchanged. In DONE, flush drops the result without a handshake.
- Mid-job async reset: all state returns to reset values immediately. The partially accumulated result is lost.
- Arithmetic: no rounding, NaN, Inf or overflow handling beyond what the adder provides. Sign of a zero acc is not normalised.

Decomposition:
- Shared package (fp_pkg): state encoding enum (IDLE/FIRST/ACC/DONE), FP32_ZERO constant, FP32 field width constants (EXP_W=8, MAN_W=23), and a zero-test function on bits [30:0].
- No sub-module. The adder stays outside and is wired to add_a/add_b/add_sum at the tile level so other controllers can share it.

Test Plan:
- Reset and idle: assert rst_n=0 mid-cycle → all outputs 0 immediately; after release busy=0, in_ready=0.
- Three-operand sum: len=3; stream 3F800000, 40000000, 3F000000 with in_valid held high → three consecutive handshakes; out_data=40600000 (3.5) one cycle after the last handshake.
- Zero bypass and back-pressure: len=4; stream 00000000, 40400000, 80000000, 3F800000 with one in_valid gap → out_data=40800000 (4.0). acc holds during the gap and when the zero is consumed.
- len=0 and output stall: start with len=0 → DONE next cycle with out_data=0. Hold out_ready=0 for 5 cycles → out_valid stays high, data stable, a start pulse is ignored. Raise out_ready → IDLE.
- Flush and reset mid-job: len=5, flush after 2 operands → IDLE next cycle, no out_valid. Repeat with rst_n pulse → acc=0 and a new len=1 job of 40000000 returns 40000000.
